// File: rtl/mem_wb_pkg.sv
// Shared pipeline-register types and widths for the ID/EX, EX/MEM and MEM/WB stages.
package mem_wb_pkg;

  localparam int SCALAR_W   = 8;
  localparam int VEC_LANES  = 16;
  localparam int VEC_LANE_W = 8;
  localparam int VEC_W      = VEC_LANES * VEC_LANE_W;
  localparam int REG_AW_P   = 5;

  typedef struct packed {
    logic                wre;
    logic                vwre;
    logic                wb_sel;
    logic [REG_AW_P-1:0] rd;
    logic [REG_AW_P-1:0] rs1;
    logic [REG_AW_P-1:0] rs2;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_wb_stage_reg_if.sv
// MEM-stage to MEM/WB-register bundle: the MEM stage drives it, the stage register samples it.
interface mem_wb_stage_reg_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 16,
  parameter int LANE_W = 8,
  parameter int REG_AW = 5
);

  logic                      in_valid;
  logic                      wre_in;
  logic                      vwre_in;
  logic                      wb_sel_in;
  logic [LANES-1:0]          lane_mask_in;
  logic [REG_AW-1:0]         rs1_in;
  logic [REG_AW-1:0]         rs2_in;
  logic [REG_AW-1:0]         rd_in;
  logic [DATA_W-1:0]         mem_data_in;
  logic [DATA_W-1:0]         calc_data_in;
  logic [LANES*LANE_W-1:0]   vmem_data_in;

  modport master (
    output in_valid, wre_in, vwre_in, wb_sel_in, lane_mask_in,
           rs1_in, rs2_in, rd_in, mem_data_in, calc_data_in, vmem_data_in
  );

  modport slave (
    input  in_valid, wre_in, vwre_in, wb_sel_in, lane_mask_in,
           rs1_in, rs2_in, rd_in, mem_data_in, calc_data_in, vmem_data_in
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline flop bank: clear zeroes only the CLR_MASK bits (others hold), hold keeps all.
module pipe_stage_reg #(
  parameter int           W        = 8,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Stage flops: clear beats hold, hold beats load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= '0;
    end else if (clear) begin
      q_r <= q_r & ~CLR_MASK;
    end else if (!hold) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM->WB stage register with valid/stall/flush, vector lane masking, WB->EX forward flags
// and a saturating retire counter.
module mem_wb_stage_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W   = SCALAR_W,
  parameter int LANES    = VEC_LANES,
  parameter int LANE_W   = VEC_LANE_W,
  parameter int REG_AW   = REG_AW_P,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic                    flush,
  mem_wb_stage_reg_if.slave       mem_bus,
  input  logic [REG_AW-1:0]       ex_rs1,
  input  logic [REG_AW-1:0]       ex_rs2,
  input  logic                    cnt_clr,
  output logic                    wb_valid,
  output logic                    wre_wb,
  output logic                    vwre_wb,
  output logic [LANES-1:0]        lane_we_wb,
  output logic [REG_AW-1:0]       rd_wb,
  output logic [REG_AW-1:0]       rs1_wb,
  output logic [REG_AW-1:0]       rs2_wb,
  output logic [DATA_W-1:0]       wb_data,
  output logic [LANES*LANE_W-1:0] vwb_data,
  output logic                    fwd_rs1,
  output logic                    fwd_rs2,
  output logic [CNT_W-1:0]        retire_count
);

  localparam int VW     = LANES * LANE_W;
  localparam int CTRL_W = 1 + $bits(wb_ctrl_t);
  localparam int DAT_W  = LANES + 2 * DATA_W + VW;
  // Flush clears valid, wre and vwre (the three MSBs); select and indices keep their old values.
  localparam logic [CTRL_W-1:0] CTRL_CLR = {3'b111, {(CTRL_W-3){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  wb_ctrl_t            ctrl_in_s;
  wb_ctrl_t            ctrl_q_s;
  logic                valid_q_s;
  logic [LANES-1:0]    lane_mask_q_s;
  logic [DATA_W-1:0]   mem_q_s;
  logic [DATA_W-1:0]   calc_q_s;
  logic [VW-1:0]       vmem_q_s;
  logic                rd_is_zero_s;
  logic [CNT_W-1:0]    cnt_r;

  assign ctrl_in_s.wre    = mem_bus.wre_in;
  assign ctrl_in_s.vwre   = mem_bus.vwre_in;
  assign ctrl_in_s.wb_sel = mem_bus.wb_sel_in;
  assign ctrl_in_s.rd     = mem_bus.rd_in;
  assign ctrl_in_s.rs1    = mem_bus.rs1_in;
  assign ctrl_in_s.rs2    = mem_bus.rs2_in;

  pipe_stage_reg #(
    .W        (CTRL_W),
    .CLR_MASK (CTRL_CLR)
  ) u_ctrl_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (stall),
    .clear   (flush),
    .d       ({mem_bus.in_valid, ctrl_in_s}),
    .q       ({valid_q_s, ctrl_q_s})
  );

  pipe_stage_reg #(
    .W        (DAT_W),
    .CLR_MASK ({DAT_W{1'b0}})
  ) u_data_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (stall),
    .clear   (flush),
    .d       ({mem_bus.lane_mask_in, mem_bus.mem_data_in, mem_bus.calc_data_in, mem_bus.vmem_data_in}),
    .q       ({lane_mask_q_s, mem_q_s, calc_q_s, vmem_q_s})
  );

  // Scalar x0 is hardwired when ZERO_REG is set; the vector file has no such register.
  assign rd_is_zero_s = (ZERO_REG != 0) && (ctrl_q_s.rd == {REG_AW{1'b0}});

  assign wb_valid   = valid_q_s;
  assign wre_wb     = ctrl_q_s.wre & valid_q_s & ~rd_is_zero_s;
  assign vwre_wb    = ctrl_q_s.vwre & valid_q_s;
  assign lane_we_wb = lane_mask_q_s & {LANES{vwre_wb}};
  assign rd_wb      = ctrl_q_s.rd;
  assign rs1_wb     = ctrl_q_s.rs1;
  assign rs2_wb     = ctrl_q_s.rs2;
  assign wb_data    = ctrl_q_s.wb_sel ? mem_q_s : calc_q_s;
  assign vwb_data   = vmem_q_s;
  assign fwd_rs1    = wre_wb && (ctrl_q_s.rd == ex_rs1);
  assign fwd_rs2    = wre_wb && (ctrl_q_s.rd == ex_rs2);

  // Retire counter: clear wins, otherwise count unstalled commits and stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (valid_q_s && !stall && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign retire_count = cnt_r;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Directed bench for mem_wb_stage_reg: vector table plus stall, flush, reset and counter sequences.
module tb_mem_wb_stage_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, flush, cnt_clr;
  logic [4:0]  ex_rs1, ex_rs2;

  logic        wb_valid, wre_wb, vwre_wb, fwd_rs1, fwd_rs2;
  logic [15:0] lane_we_wb;
  logic [4:0]  rd_wb, rs1_wb, rs2_wb;
  logic [7:0]  wb_data;
  logic [127:0] vwb_data;
  logic [31:0] retire_count;

  logic        d4_wb_valid, d4_wre_wb, d4_vwre_wb, d4_fwd_rs1, d4_fwd_rs2;
  logic [15:0] d4_lane_we_wb;
  logic [4:0]  d4_rd_wb, d4_rs1_wb, d4_rs2_wb;
  logic [7:0]  d4_wb_data;
  logic [127:0] d4_vwb_data;
  logic [3:0]  d4_retire_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage_reg_if #(.DATA_W(8), .LANES(16), .LANE_W(8), .REG_AW(5)) mem_if ();

  mem_wb_stage_reg #(.CNT_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .mem_bus(mem_if.slave),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .cnt_clr(cnt_clr),
    .wb_valid(wb_valid), .wre_wb(wre_wb), .vwre_wb(vwre_wb), .lane_we_wb(lane_we_wb),
    .rd_wb(rd_wb), .rs1_wb(rs1_wb), .rs2_wb(rs2_wb), .wb_data(wb_data), .vwb_data(vwb_data),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .retire_count(retire_count)
  );

  mem_wb_stage_reg #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .mem_bus(mem_if.slave),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .cnt_clr(cnt_clr),
    .wb_valid(d4_wb_valid), .wre_wb(d4_wre_wb), .vwre_wb(d4_vwre_wb), .lane_we_wb(d4_lane_we_wb),
    .rd_wb(d4_rd_wb), .rs1_wb(d4_rs1_wb), .rs2_wb(d4_rs2_wb), .wb_data(d4_wb_data), .vwb_data(d4_vwb_data),
    .fwd_rs1(d4_fwd_rs1), .fwd_rs2(d4_fwd_rs2), .retire_count(d4_retire_count)
  );

  typedef struct {
    logic        v, wre, vwre, sel;
    logic [15:0] mask;
    logic [4:0]  rd, rs1, rs2, ex1, ex2;
    logic [7:0]  mem, calc;
    logic [127:0] vmem;
    logic        e_wre, e_vwre;
    logic [15:0] e_lane;
    logic [7:0]  e_data;
    logic        e_f1, e_f2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    mem_if.in_valid     = t.v;
    mem_if.wre_in       = t.wre;
    mem_if.vwre_in      = t.vwre;
    mem_if.wb_sel_in    = t.sel;
    mem_if.lane_mask_in = t.mask;
    mem_if.rd_in        = t.rd;
    mem_if.rs1_in       = t.rs1;
    mem_if.rs2_in       = t.rs2;
    mem_if.mem_data_in  = t.mem;
    mem_if.calc_data_in = t.calc;
    mem_if.vmem_data_in = t.vmem;
    ex_rs1              = t.ex1;
    ex_rs2              = t.ex2;
  endtask

  task automatic drive_scalar(input logic v, input logic wre, input logic sel, input logic [4:0] rd,
                              input logic [7:0] mem, input logic [7:0] calc);
    vec_t t;
    t = '{v, wre, 1'b0, sel, 16'h0000, rd, 5'd0, 5'd0, 5'd0, 5'd0, mem, calc, 128'd0,
          1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
    drive(t);
  endtask

  initial begin
    //        v     wre   vwre  sel   mask      rd     rs1    rs2    ex1    ex2    mem    calc   vmem
    //        e_wre e_vwre e_lane   e_data e_f1 e_f2
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd3, 5'd1, 5'd2, 5'd3, 5'd4, 8'h00, 8'h5A, 128'd0,
                1'b1, 1'b0, 16'h0000, 8'h5A, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 5'd9, 5'd4, 5'd5, 5'd9, 5'd9, 8'hC3, 8'h11, 128'd0,
                1'b1, 1'b0, 16'h0000, 8'hC3, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h00F0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd6, 8'h00, 8'h22, {16{8'hAA}},
                1'b0, 1'b1, 16'h00F0, 8'h22, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'h44, 8'h55, 128'd0,
                1'b0, 1'b0, 16'h0000, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd7, 5'd7, 5'd7, 5'd1, 5'd7, 8'h00, 8'h66, 128'd0,
                1'b1, 1'b0, 16'h0000, 8'h66, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 5'd8, 5'd0, 5'd0, 5'd8, 5'd8, 8'h00, 8'h77, {16{8'h55}},
                1'b0, 1'b0, 16'h0000, 8'h77, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'h9E, 8'h00,
                128'h0123456789ABCDEF_FEDCBA9876543210,
                1'b0, 1'b1, 16'h0001, 8'h9E, 1'b0, 1'b0};

    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    drive(vecs[1]);
    repeat (2) step();
    chk("por_valid", wb_valid, 1'b0);
    chk("por_count", retire_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("v%0d_valid", i), wb_valid, vecs[i].v);
      chk($sformatf("v%0d_wre", i), wre_wb, vecs[i].e_wre);
      chk($sformatf("v%0d_vwre", i), vwre_wb, vecs[i].e_vwre);
      chk($sformatf("v%0d_lane", i), lane_we_wb, vecs[i].e_lane);
      chk($sformatf("v%0d_fwd1", i), fwd_rs1, vecs[i].e_f1);
      chk($sformatf("v%0d_fwd2", i), fwd_rs2, vecs[i].e_f2);
      if (vecs[i].v) begin
        chk($sformatf("v%0d_data", i), wb_data, vecs[i].e_data);
        chk($sformatf("v%0d_d4data", i), d4_wb_data, vecs[i].e_data);
        chk($sformatf("v%0d_vdata", i), vwb_data, vecs[i].vmem);
        chk($sformatf("v%0d_rd", i), rd_wb, vecs[i].rd);
        chk($sformatf("v%0d_rs1", i), rs1_wb, vecs[i].rs1);
        chk($sformatf("v%0d_rs2", i), rs2_wb, vecs[i].rs2);
      end
    end

    // Asynchronous reset in mid-cycle with live inputs
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", wb_valid, 1'b0);
    chk("rst_vwre", vwre_wb, 1'b0);
    chk("rst_lane", lane_we_wb, 16'h0000);
    chk("rst_data", wb_data, 8'h00);
    chk("rst_vdata", vwb_data, 128'd0);
    chk("rst_rd", rd_wb, 5'd0);
    chk("rst_count", retire_count, 32'd0);
    chk("rst_d4count", d4_retire_count, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive_scalar(1'b1, 1'b1, 1'b0, 5'd3, 8'h00, 8'h5A);
    step();
    chk("rel_data", wb_data, 8'h5A);
    chk("rel_wre", wre_wb, 1'b1);

    // Stall holds contents and retire count
    drive_scalar(1'b1, 1'b1, 1'b1, 5'd9, 8'hC3, 8'h11);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("sel_mem", wb_data, 8'hC3);
    chk("clr_count", retire_count, 32'd0);
    stall = 1'b1;
    drive_scalar(1'b0, 1'b0, 1'b0, 5'd12, 8'h88, 8'h99);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d_data", k), wb_data, 8'hC3);
      chk($sformatf("stall%0d_valid", k), wb_valid, 1'b1);
      chk($sformatf("stall%0d_rd", k), rd_wb, 5'd9);
      chk($sformatf("stall%0d_count", k), retire_count, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("unstall_count", retire_count, 32'd1);
    chk("unstall_valid", wb_valid, 1'b0);

    // Flush during stall still inserts a bubble
    drive(vecs[0]);
    mem_if.rd_in = 5'd5; mem_if.vwre_in = 1'b1; mem_if.lane_mask_in = 16'hFFFF;
    ex_rs1 = 5'd5; ex_rs2 = 5'd5;
    step();
    chk("pre_flush_fwd1", fwd_rs1, 1'b1);
    chk("pre_flush_lane", lane_we_wb, 16'hFFFF);
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    chk("flush_valid", wb_valid, 1'b0);
    chk("flush_wre", wre_wb, 1'b0);
    chk("flush_vwre", vwre_wb, 1'b0);
    chk("flush_lane", lane_we_wb, 16'h0000);
    chk("flush_fwd1", fwd_rs1, 1'b0);
    chk("flush_fwd2", fwd_rs2, 1'b0);

    // Saturation on the 4-bit counter versus free count on the 32-bit one
    drive_scalar(1'b1, 1'b1, 1'b0, 5'd2, 8'h00, 8'h01);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("sat_start", d4_retire_count, 4'd0);
    for (int k = 0; k < 20; k++) step();
    chk("sat_d4", d4_retire_count, 4'd15);
    chk("sat_d32", retire_count, 32'd20);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_prio_d4", d4_retire_count, 4'd0);
    chk("clr_prio_d32", retire_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
